conv_map_collector: RTL
=======================

// Module: conv_map_collector
// PURPOSE
//  Receiving end of the convolution stream. Accepts one signed 16-bit convolved pixel per handshake.
//  Pixels arrive in raster order: row-major, column fastest.
//  Assembles them into a flattened (N-K+1)x(N-K+1) output feature map held in a register array.
//  Raises done when the map is complete so the next CNN stage (pooling / next conv) can consume it.
//  Sits directly after the sliding-window convolver in the CNN datapath.
// PARAMETERS
//  N  10  input image side length, in pixels
//  K  5   filter side length
//  M  N-K+1 (localparam, 6 at defaults)  output feature-map side length
// PORTS
//  clk          in   1            rising-edge clock, single clock domain
//  reset        in   1            synchronous, active-high reset
//  start        in   1            1-cycle pulse; clears the map and begins collection
//  in_valid     in   1            in_data carries a convolved pixel this cycle
//  in_data      in   16 signed    convolved pixel value
//  in_ready     out  1            collector can accept a pixel this cycle
//  feature_map  out  16 signed [0:M*M-1]  collected map, index = row*M+col
//  row          out  $clog2(M)    row of the next pixel to be written
//  col          out  $clog2(M)    column of the next pixel to be written
//  done         out  1            map complete; held until start or reset
//  overflow     out  1            sticky; in_valid seen while state = FULL
// BEHAVIOUR
//  Clock and reset
//   - Single clock domain; all state updates on posedge clk.
//   - reset is synchronous, active-high.
//   - reset values: state=IDLE, feature_map all 0, row=0, col=0, in_ready=0, done=0, overflow=0.
//   - reset mid-collection discards all partial data.
//  State machine IDLE -> COLLECT -> FULL
//   - IDLE: in_ready=0; in_valid ignored, no overflow flagged. start -> COLLECT.
//   - COLLECT: in_ready=1 (registered, asserted the cycle after start).
//   - FULL: in_ready=0, done=1. start -> COLLECT; otherwise stay in FULL.
//  Collection
//   - Accept condition: in_valid & in_ready. On accept, feature_map[row*M+col] <= in_data.
//   - Counter update: col+1; when col==M-1, col=0 and row+1.
//   - Accepting the last pixel (row==M-1, col==M-1): state=FULL, done=1 and in_ready=0 next cycle.
//     Counters wrap to 0.
//   - Latency: an accepted pixel is visible on feature_map 1 cycle after its accept edge.
//  start handling
//   - start in any state: feature_map cleared to 0, row=col=0, done=0, overflow=0, state=COLLECT.
//   - start and in_valid in the same cycle: start wins and that beat is dropped (not written).
//   - start during COLLECT restarts collection; partial data is discarded.
//  Errors
//   - in_valid in FULL sets overflow; data dropped, map unchanged.
//   - in_valid with no start (IDLE) is ignored silently.
//  Arithmetic
//   - in_data is stored verbatim; no width change.
// CONFIGURATION
//  CONV_COLLECT_RELU_EN
//   - defined: applies ReLU on write; stores (in_data < 0) ? 0 : in_data.
//   - undefined: stores raw signed value.
//   - No latency or handshake difference either way.
// TESTING
//  1. Reset:
//     reset 1 cycle -> feature_map all 0, done=0, in_ready=0, row=col=0, overflow=0.
//  2. Full map:
//     start, then 36 beats in_data=k (k=0..35) -> done=1 after the 36th beat;
//     feature_map[k]=k, feature_map[7]=7 (row1,col1).
//  3. Stalls:
//     in_valid toggled 1,0,1,... over 72 cycles -> exactly 36 writes, map identical to test 2.
//  4. Start collision:
//     start with in_valid=1, in_data=99 -> map[0]=0, row=col=0;
//     next beat in_data=5 -> map[0]=5.
//  5. Overflow / restart:
//     after done, in_valid with in_data=7 -> overflow=1, map unchanged;
//     then start -> overflow=0, done=0.
//  6. Negative data, signedness:
//     in_data=-3 (16'hFFFD) -> map[0]=-3 without macro, 0 with CONV_COLLECT_RELU_EN;
//     reset mid-map (after 20 beats) -> all outputs at reset values.

Source files
------------

// File: rtl/conv_map_collector.sv
// Collects a raster-ordered stream of signed convolved pixels into an MxM feature map.
// Optional CONV_COLLECT_RELU_EN: clamp negative pixels to zero on write.
module conv_map_collector #(
  parameter int unsigned N  = 10,
  parameter int unsigned K  = 5,
  localparam int unsigned M  = N - K + 1,
  localparam int unsigned MM = M * M,
  localparam int unsigned DW = 16,
  localparam int unsigned RW = (M > 1) ? $clog2(M) : 1,
  localparam int unsigned IW = (MM > 1) ? $clog2(MM) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  output logic signed [DW-1:0] feature_map [0:MM-1],
  output logic        [RW-1:0] row,
  output logic        [RW-1:0] col,
  output logic                 done,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  accept;
  logic                  last_pixel;
  logic                  ready_nxt;
  logic                  done_nxt;
  logic signed [DW-1:0]  wr_data;
  logic        [IW-1:0]  wr_idx;

  // A start in the same cycle as a beat takes priority and drops that beat.
  always_comb begin
    accept     = in_valid & in_ready & ~start;
    last_pixel = (row == RW'(M - 1)) && (col == RW'(M - 1));
    wr_idx     = IW'(row) * IW'(M) + IW'(col);
  end

  always_comb begin
`ifdef CONV_COLLECT_RELU_EN
    wr_data = in_data[DW-1] ? '0 : in_data;
`else
    wr_data = in_data;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        COLLECT: if (accept && last_pixel) state_nxt = FULL;
        FULL:    state_nxt = FULL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode; these feed registers so in_ready/done track the state they lead into.
  always_comb begin
    ready_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state_nxt)
      COLLECT: ready_nxt = 1'b1;
      FULL:    done_nxt  = 1'b1;
      default: begin
        ready_nxt = 1'b0;
        done_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= ready_nxt;
      done     <= done_nxt;
    end
  end

  // Raster counters: column fastest, both wrap after the final pixel.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == RW'(M - 1)) begin
        col <= '0;
        row <= (row == RW'(M - 1)) ? '0 : row + RW'(1);
      end else begin
        col <= col + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      overflow <= 1'b0;
    end else if (in_valid && state == FULL) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(MM); i++) begin
      if (reset || start) begin
        feature_map[i] <= '0;
      end else if (accept && wr_idx == IW'(i)) begin
        feature_map[i] <= wr_data;
      end
    end
  end

endmodule
